input_conditioner: RTL

//  Front-end stage for the ALU controller. Synchronises and debounces the four operand buttons and four op switches.

---
 rtl/input_conditioner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: sync + debounce of 4 buttons and 4 op switches,
// button rise pulses, and a one-hot op-select FSM for the ALU controller.
//
// Ports:
//   FPGA_clk     in   system clock, rising edge
//   FPGA_reset   in   asynchronous active-high reset
//   btn_raw[3:0] in   raw bouncy buttons {btn3,btn2,btn1,btn0}
//   sw_raw[3:0]  in   raw bouncy switches {mul,sub,xor,and}
//   btn_clean    out  debounced button levels
//   btn_rise     out  one-cycle pulse on debounced button 0->1
//   sw_clean     out  debounced switch levels
//   op_code[1:0] out  00 AND, 01 XOR, 10 SUB, 11 MUL (last valid)
//   op_valid     out  exactly one switch on
//   op_conflict  out  two or more switches on
//   op_change    out  pulse when a new valid selection is taken
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       FPGA_clk,
  input  logic       FPGA_reset,
  input  logic [3:0] btn_raw,
  input  logic [3:0] sw_raw,
  output logic [3:0] btn_clean,
  output logic [3:0] btn_rise,
  output logic [3:0] sw_clean,
  output logic [1:0] op_code,
  output logic       op_valid,
  output logic       op_conflict,
  output logic       op_change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0] raw;
  logic [7:0] clean;

  assign raw       = {sw_raw, btn_raw};
  assign btn_clean = clean[3:0];
  assign sw_clean  = clean[7:4];

  for (genvar i = 0; i < 8; i++) begin : g_in
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   clean_q;
    logic                   s;
    logic                   flip;

    assign s        = sync[SYNC_STAGES-1];
    // Last cycle of a full stable run: accept the new level now.
    assign flip     = (s != clean_q) && (cnt == CNT_MAX);
    assign clean[i] = clean_q;

    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
      if (FPGA_reset) begin
        sync    <= '0;
        cnt     <= '0;
        clean_q <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw[i]};
        if (s == clean_q) begin
          cnt <= '0;
        end else if (flip) begin
          cnt     <= '0;
          clean_q <= s;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    // Pulse coincides with the first cycle the clean level reads 1.
    if (i < 4) begin : g_rise
      logic rise_q;
      assign btn_rise[i] = rise_q;
      always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) rise_q <= 1'b0;
        else            rise_q <= flip & s;
      end
    end
  end

  typedef enum logic [1:0] {
    IDLE,
    VALID,
    CONFLICT
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] pop;
  logic [1:0] code_enc, code_d;
  logic       change_d;

  assign pop = {2'b0, sw_clean[0]} + {2'b0, sw_clean[1]}
             + {2'b0, sw_clean[2]} + {2'b0, sw_clean[3]};

  assign code_enc = {sw_clean[2] | sw_clean[3],
                     sw_clean[1] | sw_clean[3]};

  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      state_q   <= IDLE;
      op_code   <= 2'b00;
      op_change <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_code   <= code_d;
      op_change <= change_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = op_code;
    change_d = 1'b0;
    unique case (1'b1)
      (pop == 3'd0): state_d = IDLE;
      (pop == 3'd1): begin
        state_d  = VALID;
        code_d   = code_enc;
        // Entry from IDLE/CONFLICT, or a direct swap, is a new selection.
        change_d = (state_q != VALID) || (code_enc != op_code);
      end
      default: state_d = CONFLICT;
    endcase
  end

  assign op_valid    = (state_q == VALID);
  assign op_conflict = (state_q == CONFLICT);

endmodule
